ysyx_22051013_ex_muldiv: RTL and testbench
==========================================

# ysyx_22051013_ex_muldiv

Iterative RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the registered operands and M-extension decode of the instruction held in EX. It raises a stall request that holds ID/EX and earlier stages until a result is produced. It returns one 64-bit result, sign-extended for W-variants, which the EX result mux forwards to EX/MEM.

## Interface
- XLEN, 64, datapath width; only 64 is supported.
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  EX holds a valid M-extension instruction
- flush  in  1  EX instruction is killed (same source as ID/EX flush)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- word  in  1  W-variant: MULW, DIVW, DIVUW, REMW, REMUW; funct3 001–011 with word=1 is treated as MULW
- op1  in  XLEN  rs1 value
- op2  in  XLEN  rs2 value
- stall_req  out  1  hold EX and all upstream stages this cycle
- done  out  1  result valid; pulses for one cycle
- result  out  XLEN  final result; meaningful only while done=1

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY when start=1, flush=0, and no special case applies. In that cycle:
  - latch operand magnitudes, result-sign flags, funct3 and word;
  - W-variants take the low 32 bits of each operand, sign-extended or zero-extended per signedness;
  - load cnt = 64 (32 for word).
- IDLE → DONE directly on a division special case:
  - divisor = 0: quotient = all ones; remainder = dividend.
  - signed overflow (dividend = most-negative, divisor = −1, at the active width): quotient = dividend; remainder = 0.
- BUSY: one iteration per cycle; cnt decrements; BUSY → DONE when cnt reaches 1.
  - Multiply: radix-2 shift-add on magnitudes into a 128-bit accumulator.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
- DONE → IDLE unconditionally. start is not sampled in DONE: the EX instruction advances on that edge.
- Sign fix-up, applied to the registered result when entering DONE:
  - Product is negated if exactly one signed operand was negative. MULHSU treats only op1 as signed.
  - Quotient is negated on operand sign mismatch.
  - Remainder takes the sign of the dividend.
- Result select:
  - MUL: low 64 bits of the product.
  - MULH, MULHSU, MULHU: high 64 bits of the product.
  - DIV/REM: quotient/remainder.
  - Word: bits [31:0] of the result, sign-extended to 64.
- flush has priority in every state: next state is IDLE, done is suppressed, and the partial result is discarded.
- Outputs:
  - stall_req = (IDLE & start & ~flush) | BUSY.
  - done = DONE & ~flush.
  - result is registered and held until the next acceptance.
- Reset (rst=0), including mid-operation: state = IDLE, cnt = 0, accumulators = 0, result = 0, done = 0, stall_req = 0 (for an inactive start).

## Timing
- Acceptance edge T: start seen in IDLE.
- Normal ops: BUSY for N cycles, with N = 64 (XLEN) or 32 (word). done=1 in cycle T+N+1. stall_req is high from the start cycle through T+N and low in the done cycle.
- Special-case divide: done in cycle T+1; stall_req high only in the start cycle.
- Back-to-back M instructions: the second is accepted in the cycle after DONE. No bubble is needed beyond the DONE cycle.
- flush in BUSY at cycle k: IDLE at k+1; stall_req drops at k+1; done never asserts for that instruction.
- Simultaneous start and flush in IDLE: not accepted; stall_req=0.
- No combinational path from op1/op2 to any output. stall_req depends combinationally only on start, flush and state.

## Structure
- Shared package/define file holds:
  - XLEN;
  - funct3 codes MUL..REMU;
  - state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - iteration counts 64/32.
- One sub-module: ysyx_22051013_div_step. It is the combinational single-iteration restoring-divide step: (rem, quo, divisor) → (rem', quo'). The multiply step stays inline.
- The top level holds the FSM, counter, sign/magnitude pre- and post-processing, and the result mux.

## Test plan
- MUL, op1=3, op2=0xFFFF_FFFF_FFFF_FFFB (−5) → result 0xFFFF_FFFF_FFFF_FFF1. done at T+65; stall_req high for 65 cycles.
- MULHU, op1 = op2 = 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH on the same operands → 0.
- DIVW, op1=0xFFFF_FFFF_FFFF_FFF9 (−7), op2=2 → 0xFFFF_FFFF_FFFF_FFFD, done at T+33. REMW on the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- Special cases:
  - DIVU by 0 → all ones; REM by 0, op1=0x1234 → 0x1234. Both with done at T+1.
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000; REM of the same → 0.
- Abort:
  - flush asserted 10 cycles into a DIV → IDLE next cycle, stall_req low, no done pulse.
  - A following MUL 6×7 → 42 with full latency.
- Reset and back-to-back:
  - rst pulled low asynchronously mid-BUSY (between edges) → stall_req, done and result go to 0 immediately.
  - After release with start low, the unit stays idle.
  - Back-to-back MUL then DIVU issue with exactly one DONE cycle between them.

Source files
------------

// File: rtl/ysyx_22051013_ex_muldiv_pkg.sv
// Shared definitions for the EX-stage RV64M multiply/divide unit: widths,
// funct3 codes, FSM encoding and iteration counts.
package ysyx_22051013_ex_muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [CNT_W-1:0] ITER_XLEN = 7'd64;
  localparam logic [CNT_W-1:0] ITER_WORD = 7'd32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_div_op(input funct3_e f);
    return f inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22051013_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift in a quotient bit.
module ysyx_22051013_div_step
  import ysyx_22051013_ex_muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dsor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, dsor_i};
    // The partial remainder stays below the divisor, so bit XLEN of the
    // difference is a reliable borrow flag.
    fits    = ~diff[XLEN];
    rem_o   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/ysyx_22051013_ex_muldiv.sv
// EX-stage iterative RV64M unit: radix-2 shift-add multiply and restoring divide
// on magnitudes, stalling upstream stages until a one-cycle done pulse.
module ysyx_22051013_ex_muldiv
  import ysyx_22051013_ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;   // multiply: {partial high, multiplier}; divide: {rem, quo}
  logic [XLEN-1:0]   opb_q, opb_d;   // multiplicand or divisor magnitude
  funct3_e           f3_q, f3_d;
  logic              word_q, word_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic accept;

  // ---------------------------------------------------------------------------
  // Operand pre-processing at acceptance
  // ---------------------------------------------------------------------------
  funct3_e         f3_eff;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] spec_quo, spec_rem, spec_sel, spec_res;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missing
    // assignment on some branch would infer a latch.
    f3_eff   = (word && !funct3[2]) ? F3_MUL : funct3_e'(funct3);
    a_signed = f3_eff inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed = f3_eff inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};

    if (word) begin
      a_ext = a_signed ? sext_word(op1[31:0]) : {{(XLEN-32){1'b0}}, op1[31:0]};
      b_ext = b_signed ? sext_word(op2[31:0]) : {{(XLEN-32){1'b0}}, op2[31:0]};
    end else begin
      a_ext = op1;
      b_ext = op2;
    end

    a_neg = a_signed & a_ext[XLEN-1];
    b_neg = b_signed & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    min_neg  = word ? sext_word(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div_op(f3_eff) && (b_ext == '0);
    div_ovf  = is_div_op(f3_eff) && b_signed && (a_ext == min_neg) && (b_ext == '1);
    special  = div_zero || div_ovf;

    spec_quo = div_zero ? '1 : a_ext;
    spec_rem = div_zero ? a_ext : '0;
    spec_sel = (f3_eff inside {F3_REM, F3_REMU}) ? spec_rem : spec_quo;
    spec_res = word ? sext_word(spec_sel[31:0]) : spec_sel;
  end

  // ---------------------------------------------------------------------------
  // One iteration per BUSY cycle
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [2*XLEN-1:0] iter_next;

  ysyx_22051013_div_step u_div_step (
    .rem_i  (acc_q[2*XLEN-1:XLEN]),
    .quo_i  (acc_q[XLEN-1:0]),
    .dsor_i (opb_q),
    .rem_o  (div_rem),
    .quo_o  (div_quo)
  );

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q & {XLEN{acc_q[0]}}};
    iter_next = is_div_op(f3_q) ? {div_rem, div_quo} : {mul_sum, acc_q[XLEN-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result select on the final iteration
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_mag, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, sel_res, final_res;

  always_comb begin
    // A 32-iteration multiply leaves the product shifted up by 32 bits.
    prod_mag = word_q ? {{XLEN{1'b0}}, iter_next[XLEN+31:32]} : iter_next;
    prod_fix = neg_q ? -prod_mag : prod_mag;
    quo_fix  = neg_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
    rem_fix  = rem_neg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                       sel_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: sel_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              sel_res = quo_fix;
      default:                      sel_res = rem_fix;
    endcase
    final_res = word_q ? sext_word(sel_res[31:0]) : sel_res;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of statement order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = special ? DONE : BUSY;
      BUSY:    if (cnt_q == 7'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    accept    = (state_q == IDLE) && start && !flush;
    stall_req = accept || (state_q == BUSY);
    done      = (state_q == DONE) && !flush;
  end

  assign result = result_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    f3_d      = f3_q;
    word_d    = word_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    if (accept) begin
      f3_d      = f3_eff;
      word_d    = word;
      neg_d     = a_neg ^ b_neg;
      rem_neg_d = a_neg;
      if (special) begin
        cnt_d    = '0;
        result_d = spec_res;
      end else if (is_div_op(f3_eff)) begin
        cnt_d = word ? ITER_WORD : ITER_XLEN;
        acc_d = {{XLEN{1'b0}}, word ? {a_mag[31:0], 32'h0} : a_mag};
        opb_d = b_mag;
      end else begin
        cnt_d = word ? ITER_WORD : ITER_XLEN;
        acc_d = {{XLEN{1'b0}}, b_mag};
        opb_d = a_mag;
      end
    end else if (state_q == BUSY) begin
      if (flush) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q - 7'd1;
        acc_d = iter_next;
        if (cnt_q == 7'd1) result_d = final_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      f3_q      <= F3_MUL;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      f3_q      <= f3_d;
      word_q    <= word_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_ex_muldiv.sv
// Self-checking bench for ysyx_22051013_ex_muldiv: directed literal cases plus
// randomized ops compared every cycle against an arithmetic reference model.
module tb_ysyx_22051013_ex_muldiv;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk, rst, start, flush, word, stall_req, done;
  logic [2:0]  funct3;
  logic [63:0] op1, op2, result;

  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          s_lo  = 1;
  int          s_hi  = 0;
  int          d_cyc = -1;
  logic [63:0] exp_res = '0;

  ysyx_22051013_ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .funct3    (funct3),
    .word      (word),
    .op1       (op1),
    .op2       (op2),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain arithmetic on the architectural definition
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, prod;
    logic signed [63:0]  sa, sb, s64;
    logic [63:0]         u64;
    logic signed [31:0]  sa32, sb32, s32;
    logic [31:0]         ua32, ub32, u32;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    if (!f3[2]) begin
      if (w) begin
        s32 = sa32 * sb32;
        return {{32{s32[31]}}, s32};
      end
      pa   = (f3 == F_MULHU) ? {64'b0, a} : {{64{a[63]}}, a};
      pb   = (f3 == F_MULHSU || f3 == F_MULHU) ? {64'b0, b} : {{64{b[63]}}, b};
      prod = pa * pb;
      return (f3 == F_MUL) ? prod[63:0] : prod[127:64];
    end
    if (w) begin
      s32 = 0; u32 = 0;
      case (f3)
        F_DIV:   s32 = (sb32 == 0) ? -32'sd1 : (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) ? sa32 : sa32 / sb32;
        F_REM:   s32 = (sb32 == 0) ? sa32 : (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) ? 32'sd0 : sa32 % sb32;
        F_DIVU:  u32 = (ub32 == 0) ? 32'hFFFF_FFFF : ua32 / ub32;
        default: u32 = (ub32 == 0) ? ua32 : ua32 % ub32;
      endcase
      if (f3[0]) return {{32{u32[31]}}, u32};
      return {{32{s32[31]}}, s32};
    end
    s64 = 0; u64 = 0;
    case (f3)
      F_DIV:   s64 = (sb == 0) ? -64'sd1 : (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) ? sa : sa / sb;
      F_REM:   s64 = (sb == 0) ? sa : (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) ? 64'sd0 : sa % sb;
      F_DIVU:  u64 = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      default: u64 = (b == 0) ? a : a % b;
    endcase
    return f3[0] ? u64 : s64;
  endfunction

  // Busy cycles an op needs: none for the divide special cases.
  function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (!f3[2]) return w ? 32 : 64;
    if (w) begin
      zero = (b[31:0] == 32'h0);
      ovf  = !f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      zero = (b == 64'h0);
      ovf  = !f3[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
    end
    if (zero || ovf) return 0;
    return w ? 32 : 64;
  endfunction

  // Compare process: every cycle, against the expected stall/done windows.
  always @(negedge clk) begin
    check("stall_req", 64'(stall_req), 64'(cyc >= s_lo && cyc <= s_hi));
    check("done", 64'(done), 64'(cyc == d_cyc));
    if (cyc == d_cyc) check("result", result, exp_res);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output int n);
    n       = ref_lat(f3, w, a, b);
    start   = 1'b1;
    funct3  = f3;
    word    = w;
    op1     = a;
    op2     = b;
    s_lo    = cyc;
    s_hi    = cyc + n;
    d_cyc   = cyc + n + 1;
    exp_res = ref_model(f3, w, a, b);
  endtask

  // Returns in the done cycle with start still held, as EX would.
  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    int n;
    launch(f3, w, a, b, n);
    repeat (n + 1) tick();
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      tick();
      start = 1'b0;
    end
    tick();
  endtask

  task automatic directed(input string name, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] lit, input int gapk);
    check({"model_", name}, ref_model(f3, w, a, b), lit);
    issue(f3, w, a, b);
    check({name, "_result"}, result, lit);
    check({name, "_done"}, 64'(done), 64'd1);
    gap(gapk);
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {$urandom, 32'h8000_0000};
      4:       return 64'($urandom_range(0, 20));
      5:       return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    int          n;

    rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b0; word = 1'b0; op1 = '0; op2 = '0;
    #12;
    check("reset_stall", 64'(stall_req), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    tick();
    rst = 1'b1;
    gap(1);

    directed("mul_3_m5", F_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 1);
    directed("mulhu_ones", F_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    directed("mulh_ones", F_MULH, 1'b0, '1, '1, 64'h0, 1);
    directed("mulhsu_m1_2", F_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    directed("mulw_wrap", F_MULHU, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    directed("divw_m7_2", F_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1);
    directed("remw_m7_2", F_REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    directed("remu_100_7", F_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1);
    directed("divu_by0", F_DIVU, 1'b0, 64'd99, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    directed("rem_by0", F_REM, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
    directed("divuw_by0", F_DIVU, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    directed("div_ovf", F_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    directed("rem_ovf", F_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1);

    // Flush ten cycles into a divide: no done pulse, idle on the next cycle.
    launch(F_DIV, 1'b0, 64'd1000, 64'd7, n);
    repeat (10) tick();
    flush = 1'b1; start = 1'b0; s_hi = cyc; d_cyc = -1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_stall_drop", 64'(stall_req), 64'd0);
    repeat (3) tick();
    directed("mul_after_flush", F_MUL, 1'b0, 64'd6, 64'd7, 64'd42, 1);

    // Start together with flush in IDLE is not accepted.
    start = 1'b1; flush = 1'b1; funct3 = F_DIV; word = 1'b0; op1 = 64'd9; op2 = 64'd3;
    #1;
    check("start_flush_stall", 64'(stall_req), 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    repeat (2) tick();

    // Asynchronous reset between edges while busy.
    launch(F_MUL, 1'b0, 64'd12345, 64'd678, n);
    repeat (20) tick();
    #2;
    rst = 1'b0; start = 1'b0; s_hi = cyc - 1; d_cyc = -1;
    #1;
    check("async_rst_stall", 64'(stall_req), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_result", result, 64'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("post_rst_result", result, 64'd0);

    // Back-to-back: the DIVU starts the cycle after the MUL's done pulse.
    directed("b2b_mul", F_MUL, 1'b0, 64'd123456789, 64'd1000, 64'd123456789000, 0);
    directed("b2b_divu", F_DIVU, 1'b0, 64'd1000, 64'd7, 64'd142, 1);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = rand_op();
      b  = rand_op();
      issue(f3, w, a, b);
      check("rand_done", 64'(done), 64'd1);
      gap($urandom_range(0, 2));
    end

    start = 1'b0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
